bennett_clock_seq: RTL

- Parametrised successor to the fixed 5-phase Bennett clock generator.
- Produces PHASES-wide sequentially ramped power-clock phases for reversible/adiabatic logic, e.g. the 2-port SRAM bank and its datapath.
- Adds per-step dwell, a minimum top hold, a stall at top-of-swing, a runtime active-phase count and a completed-cycle counter.
- Its instFlag output is the instruction-boundary strobe used as the SRAM srclk source.

---
 rtl/bennett_clock_seq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/bennett_clock_seq.sv
// Bennett power-clock sequencer: ramps PHASES phases up in order, holds at top, ramps down in
// reverse, then pulses instFlag. Define BENNETT_CLKN_EN to add the registered complement clkn.
module bennett_clock_seq #(
    parameter int unsigned PHASES      = 5,
    parameter int unsigned STEP_CYCLES = 1,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        stall,
    input  logic [$clog2(PHASES+1)-1:0] n_active,
    output logic [PHASES-1:0]           clkp,
    output logic                        instFlag,
    output logic                        busy,
`ifdef BENNETT_CLKN_EN
    output logic [PHASES-1:0]           clkn,
`endif
    output logic [CNT_W-1:0]            cyc_count
);

    localparam int unsigned IW = $clog2(PHASES + 1);
    localparam int unsigned SW = $clog2(STEP_CYCLES + 1);
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [IW-1:0] PhasesN  = IW'(PHASES);
    localparam logic [SW-1:0] StepLast = SW'(STEP_CYCLES - 1);
    localparam logic [HW-1:0] HoldLast = HW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRise,
        StTop,
        StFall,
        StBottom
    } state_e;

    state_e          state;
    logic [IW-1:0]   n_lat;
    logic [IW-1:0]   n_clamp;
    // Number of phases currently high; the high set is always clkp[idx-1:0].
    logic [IW-1:0]   idx;
    logic [SW-1:0]   step_cnt;
    logic [HW-1:0]   hold_cnt;

    always_comb begin
        n_clamp = n_active;
        if (n_active == '0 || n_active > PhasesN) begin
            n_clamp = PhasesN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            n_lat     <= '0;
            idx       <= '0;
            step_cnt  <= '0;
            hold_cnt  <= '0;
            clkp      <= '0;
            instFlag  <= 1'b0;
            busy      <= 1'b0;
            cyc_count <= '0;
`ifdef BENNETT_CLKN_EN
            clkn      <= '1;
`endif
        end else begin
            instFlag <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (en) begin
                        state    <= StRise;
                        n_lat    <= n_clamp;
                        idx      <= '0;
                        step_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end

                StRise: begin
                    if (step_cnt == StepLast) begin
                        step_cnt <= '0;
                        clkp     <= {clkp[PHASES-2:0], 1'b1};
`ifdef BENNETT_CLKN_EN
                        clkn     <= ~{clkp[PHASES-2:0], 1'b1};
`endif
                        idx      <= idx + IW'(1);
                        if (idx == n_lat - IW'(1)) begin
                            state    <= StTop;
                            hold_cnt <= '0;
                        end
                    end else begin
                        step_cnt <= step_cnt + SW'(1);
                    end
                end

                StTop: begin
                    // Hold count saturates so a long stall leaves on the first edge it is low.
                    if (hold_cnt == HoldLast) begin
                        if (!stall) begin
                            state    <= StFall;
                            step_cnt <= '0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end

                StFall: begin
                    if (step_cnt == StepLast) begin
                        step_cnt <= '0;
                        clkp     <= clkp >> 1;
`ifdef BENNETT_CLKN_EN
                        clkn     <= ~(clkp >> 1);
`endif
                        idx      <= idx - IW'(1);
                        if (idx == IW'(1)) begin
                            state     <= StBottom;
                            instFlag  <= 1'b1;
                            cyc_count <= cyc_count + CNT_W'(1);
                        end
                    end else begin
                        step_cnt <= step_cnt + SW'(1);
                    end
                end

                StBottom: begin
                    if (en) begin
                        state    <= StRise;
                        n_lat    <= n_clamp;
                        idx      <= '0;
                        step_cnt <= '0;
                    end else begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
